// File: rtl/seq_scan_pkg.sv
// Shared encodings for the word-scanning controller and its serial 1101 detector.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } ctrl_state_e;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_e;

  localparam logic [3:0] PAT = 4'b1101;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / count-out handshake bundle between a bus producer/consumer and seq_scan_ctrl.
interface seq_scan_ctrl_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_restart;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_restart, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, in_restart, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/pattern_det_1101.sv
// Moore detector for 1101 with overlap; advances only when en=1, clr wins over en.
module pattern_det_1101
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic x,
  output logic y
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = (x == PAT[3]) ? S1 : S0;
      S1:      state_d = (x == PAT[2]) ? S2 : S0;
      S2:      state_d = (x == PAT[1]) ? S3 : S2;
      S3:      state_d = (x == PAT[0]) ? S4 : S0;
      S4:      state_d = x ? S2 : S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q <= S0;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  assign y = (state_q == S4);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Shifts accepted words MSB-first into the 1101 detector and reports a saturating match count.
// WORD_W+3 cycles per word minimum; the count is held in REPORT until out_ready, no accept meanwhile.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  seq_scan_ctrl_if.slave  bus,
  output logic            det_y
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);

  ctrl_state_e       state_q;
  logic [WORD_W-1:0] sh_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  out_count_q;

  logic accept;
  logic det_en;
  logic det_clr;
  logic count_en;

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign det_en  = (state_q == SHIFT);
  assign det_clr = accept && bus.in_restart;

  // det_y in the first SHIFT cycle belongs to the previous word's last bit and was already counted.
  assign count_en = det_y && (((state_q == SHIFT) && (idx_q != IDX_TOP)) || (state_q == DRAIN));
  assign cnt_d    = (count_en && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sh_q       <= bus.in_data;
            idx_q      <= IDX_TOP;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q  <= {sh_q[WORD_W-2:0], 1'b0};
          cnt_q <= cnt_d;
          if (idx_q == '0) begin
            state_q <= DRAIN;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DRAIN: begin
          cnt_q       <= cnt_d;
          out_count_q <= cnt_d;
          out_valid_q <= 1'b1;
          state_q     <= REPORT;
        end
        REPORT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;

  pattern_det_1101 u_det (
    .clk   (clk),
    .reset (reset),
    .en    (det_en),
    .clr   (det_clr),
    .x     (sh_q[WORD_W-1]),
    .y     (det_y)
  );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: an 8-bit/4-bit instance and a 16-bit/2-bit saturation instance.
module tb_seq_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic det_y8, det_y16;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.WORD_W(8),  .CNT_W(4)) b8 ();
  seq_scan_ctrl_if #(.WORD_W(16), .CNT_W(2)) b16 ();

  seq_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8),
    .det_y (det_y8)
  );

  seq_scan_ctrl #(.WORD_W(16), .CNT_W(2)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16),
    .det_y (det_y16)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_rdy8();
    int waited = 0;
    while (!b8.in_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (!b8.in_ready) chk("rdy_wait8", 32'(b8.in_ready), 32'd1);
  endtask

  // Sends one word, returns the cycle (after acceptance) where out_valid rose, the count and a det_y bitmap.
  task automatic run8(input logic rst_in, input logic [7:0] d, input logic ordy,
                      output int lat, output logic [3:0] cnt, output logic [31:0] yp);
    lat = 0;
    cnt = '0;
    yp  = '0;
    wait_rdy8();
    b8.in_valid   = 1'b1;
    b8.in_data    = d;
    b8.in_restart = rst_in;
    b8.out_ready  = ordy;
    @(negedge clk);
    b8.in_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      yp[k] = det_y8;
      if (b8.out_valid) begin
        lat = k;
        cnt = b8.out_count;
        break;
      end
      @(negedge clk);
    end
  endtask

  int          lat;
  logic [3:0]  cnt;
  logic [31:0] yp;

  initial begin
    reset = 1'b1;
    b8.in_valid = 1'b0;  b8.in_data = '0;  b8.in_restart = 1'b0;  b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_restart = 1'b0; b16.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(b8.in_ready),  32'd1);
    chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
    chk("rst_out_count", 32'(b8.out_count), 32'd0);
    chk("rst_det_y",     32'(det_y8),       32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1101_0000: one match, det_y high in cycle 5, report in cycle 10
    run8(1'b1, 8'hD0, 1'b1, lat, cnt, yp);
    chk("d0_lat", 32'(lat), 32'd10);
    chk("d0_cnt", 32'(cnt), 32'd1);
    chk("d0_y",   yp,       32'h0000_0020);

    // 1101_1011: overlap via S4->S2, pulses in cycles 5 and 8
    run8(1'b1, 8'hDB, 1'b1, lat, cnt, yp);
    chk("db_lat", 32'(lat), 32'd10);
    chk("db_cnt", 32'(cnt), 32'd2);
    chk("db_y",   yp,       32'h0000_0120);

    // pattern straddling two words counted in the later word unless restarted
    run8(1'b1, 8'h03, 1'b1, lat, cnt, yp);
    chk("str_a_cnt", 32'(cnt), 32'd0);
    run8(1'b0, 8'h40, 1'b1, lat, cnt, yp);
    chk("str_b_cnt", 32'(cnt), 32'd1);
    run8(1'b1, 8'h03, 1'b1, lat, cnt, yp);
    chk("rst_a_cnt", 32'(cnt), 32'd0);
    run8(1'b1, 8'h40, 1'b1, lat, cnt, yp);
    chk("rst_b_cnt", 32'(cnt), 32'd0);

    // backpressure in REPORT with in_valid toggling
    run8(1'b1, 8'hDB, 1'b0, lat, cnt, yp);
    chk("bp_lat", 32'(lat), 32'd10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(b8.out_valid), 32'd1);
      chk("bp_out_count", 32'(b8.out_count), 32'd2);
      chk("bp_in_ready",  32'(b8.in_ready),  32'd0);
      b8.in_valid   = ~b8.in_valid;
      b8.in_data    = 8'hFF;
      b8.in_restart = 1'b1;
      @(negedge clk);
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_out_valid", 32'(b8.out_valid), 32'd0);
    chk("bp_rel_in_ready",  32'(b8.in_ready),  32'd1);
    chk("bp_rel_count",     32'(b8.out_count), 32'd2);

    // reset in SHIFT cycle 4
    wait_rdy8();
    b8.in_valid   = 1'b1;
    b8.in_data    = 8'hDB;
    b8.in_restart = 1'b0;
    @(negedge clk);
    b8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_in_ready",  32'(b8.in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(b8.out_valid), 32'd0);
    chk("mid_rst_out_count", 32'(b8.out_count), 32'd0);
    chk("mid_rst_det_y",     32'(det_y8),       32'd0);
    run8(1'b0, 8'hD0, 1'b1, lat, cnt, yp);
    chk("post_rst_lat", 32'(lat), 32'd10);
    chk("post_rst_cnt", 32'(cnt), 32'd1);

    // 16-bit word with five matches saturates a 2-bit counter at 3
    begin
      int waited = 0;
      int lat16 = 0;
      logic [1:0] cnt16 = '0;
      while (!b16.in_ready && waited < 30) begin
        @(negedge clk);
        waited++;
      end
      b16.in_valid   = 1'b1;
      b16.in_data    = 16'hDB6D;
      b16.in_restart = 1'b1;
      @(negedge clk);
      b16.in_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        if (b16.out_valid) begin
          lat16 = k;
          cnt16 = b16.out_count;
          break;
        end
        @(negedge clk);
      end
      chk("sat_lat", 32'(lat16), 32'd18);
      chk("sat_cnt", 32'(cnt16), 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Word-level controller that sequences a serial Moore pattern detector.
- Accepts parallel words over a valid/ready handshake and shifts them MSB-first, one bit per clock, into an embedded "1101" detector (overlapping matches allowed).
- Counts matches per word and returns the count over a second valid/ready handshake.
- Sits between a parallel bus producer and the serial detection datapath; it is the only block that drives the detector's bit input and enable.

Parameters:
- WORD_W, 8, bits per accepted word (legal range 2..32).
- CNT_W, 4, width of the per-word match counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller can accept a word.
- in_data  input  WORD_W  word to scan; bit WORD_W-1 is shifted first.
- in_restart  input  1  sampled with the word: clear detector to S0 before scanning it.
- out_valid  output  1  match count available.
- out_ready  input  1  consumer takes the count.
- out_count  output  CNT_W  matches found in the last word (saturating).
- det_y  output  1  detector Moore output (state==S4), for observation only.

Behaviour:
- Reset: synchronous, active-high. Sampled high at a clock edge, it sets the following, overriding every other input in that cycle, including during SHIFT, DRAIN and REPORT:
  - ctrl FSM -> IDLE, detector -> S0, counter -> 0;
  - in_ready=1, out_valid=0, out_count=0, det_y=0.
- Controller states: IDLE, SHIFT, DRAIN, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (acceptance, cycle 0): capture in_data into the shift register, bit index <= WORD_W-1, counter <= 0, state -> SHIFT.
  - If in_restart=1 at acceptance, the detector is forced to S0 at the same edge. Otherwise its state carries over from the previous word, so patterns straddling words are counted in the later word.
- SHIFT (cycles 1..WORD_W):
  - in_ready=0.
  - Present shift-register MSB to the detector with enable=1, then shift left.
  - After the cycle with bit index 0, go to DRAIN.
- DRAIN (cycle WORD_W+1): detector enable=0, state held. Go to REPORT.
- Counting:
  - The counter increments when det_y=1 in cycles 2..WORD_W+1 (SHIFT after its first cycle, plus DRAIN).
  - det_y in SHIFT cycle 1 reflects the previous word's last bit, which was already counted. It is not recounted.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
- REPORT (cycle WORD_W+2 onward):
  - out_valid=1 and out_count=counter, both held stable until out_valid&out_ready.
  - On handshake: state -> IDLE, out_valid deasserts next cycle.
  - in_ready=0 in REPORT, so there is no same-cycle accept.
  - Minimum period is WORD_W+3 cycles per word.
- out_count keeps its last value after the handshake; it changes only at reset or at the next REPORT.
- in_valid outside IDLE is ignored; in_data and in_restart are don't-care then.
- Detector (Moore, state registered, advances only when enable=1; transitions listed as next state for input 1 / input 0):
  - S0: S1 / S0
  - S1: S2 / S0
  - S2: S2 / S3
  - S3: S4 / S0
  - S4: S2 / S0
  - Illegal encodings -> S0.
  - det_y = (state==S4).

Decomposition:
- Shared package seq_scan_pkg:
  - controller state encodings (IDLE/SHIFT/DRAIN/REPORT, 2 bits);
  - detector state encodings (S0..S4, 3 bits);
  - constant PAT = 4'b1101.
- One sub-module, pattern_det_1101:
  - ports clk, reset, en, clr, x, y;
  - clr takes priority over en;
  - it is the Moore detector above.
- Counter, shift register and handshake FSM stay in seq_scan_ctrl.

Test Plan:
- WORD_W=8, restart=1, in_data=8'hD0 (1101_0000), out_ready=1 -> out_valid in cycle 10 after acceptance, out_count=1.
- restart=1, in_data=8'hDB -> out_count=2 (overlap through S4->S2); det_y pulses in cycles 5 and 8.
- Straddling words, both completed before the second is sent:
  - restart=1 8'h03, then restart=0 8'h40 -> counts 0 then 1;
  - repeat with restart=1 on the second word -> counts 0 then 0.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT, toggling in_valid -> out_valid and out_count stable, in_ready=0, no word accepted; release -> IDLE next cycle.
- Reset asserted in SHIFT cycle 4 -> next cycle IDLE, in_ready=1, out_valid=0, out_count=0, det_y=0; then restart=0 8'hD0 -> out_count=1 (detector started from S0).
- WORD_W=16, CNT_W=2, restart=1, in_data=16'hDB6D (5 matches) -> out_count=3 (saturated, no wrap).
